// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writes a little-endian byte-stream image into instruction memory and
// holds the CPU in reset until the image is complete. Optional macro: INSTR_MEM_LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_wren,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam int          CW      = ADDR_WIDTH + 1;
    localparam logic [32:0] MAX_EXT = 33'(MAX_WORDS);

    // ST_LAST is the commit cycle of the final write, so the CPU is released only afterwards.
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_LOAD, ST_LAST, ST_CHECK, ST_DONE, ST_ERROR} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_HEADER, ST_LOAD, ST_LAST, ST_DONE, ST_ERROR} state_t;
`endif

    state_t                state_reg, state_next;
    logic [1:0]            byte_cnt_reg;
    logic [7:0]            lane_reg [3];
    logic [CW-1:0]         n_words_reg;
    logic [CW-1:0]         word_count_reg;
    logic                  mem_wren_reg;
    logic [ADDR_WIDTH-1:0] mem_address_reg;
    logic [31:0]           mem_write_data_reg;
    logic                  in_ready_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic                  error_reg;
    logic                  cpu_reset_n_reg;

    logic                  accept;
    logic                  byte_accept;
    logic                  word_last_byte;
    logic [31:0]           word_full;
    logic                  n_over;
    logic                  last_word;
    logic                  start_ok;
    logic                  wr_fire;
    logic                  next_in_check;
    logic                  sum_ok;

    assign accept         = in_valid & in_ready_reg;
    assign byte_accept    = accept & ((state_reg == ST_HEADER) | (state_reg == ST_LOAD));
    assign word_last_byte = byte_accept & (byte_cnt_reg == 2'd3);
    assign word_full      = {in_data, lane_reg[2], lane_reg[1], lane_reg[0]};
    assign n_over         = {1'b0, word_full} > MAX_EXT;
    assign last_word      = (word_count_reg + CW'(1)) == n_words_reg;
    assign start_ok       = start & ((state_reg == ST_IDLE) | (state_reg == ST_DONE) |
                                     (state_reg == ST_ERROR));
    assign wr_fire        = (state_reg == ST_LOAD) & word_last_byte;

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    logic [7:0] sum_reg;
    logic [7:0] sum_plus;

    assign sum_plus      = sum_reg + in_data;
    assign sum_ok        = (sum_plus == 8'd0);
    assign next_in_check = (state_next == ST_CHECK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_reg <= 8'd0;
        end else if (start_ok) begin
            sum_reg <= 8'd0;
        end else if (byte_accept) begin
            sum_reg <= sum_plus;
        end
    end
`else
    assign sum_ok        = 1'b0;
    assign next_in_check = 1'b0;
`endif

    // The 2-bit byte counter steers each accepted byte into its little-endian lane.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    lane_reg[gi] <= 8'd0;
                end else if (byte_accept && (byte_cnt_reg == 2'(gi))) begin
                    lane_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_next = ST_HEADER;
            end
            ST_HEADER: begin
                if (word_last_byte) begin
                    if (word_full == 32'd0) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                        state_next = ST_CHECK;
`else
                        state_next = ST_DONE;
`endif
                    end else if (n_over) begin
                        state_next = ST_ERROR;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (word_last_byte && last_word) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_LAST;
`endif
                end
            end
            ST_LAST: state_next = ST_DONE;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) state_next = sum_ok ? ST_DONE : ST_ERROR;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= ST_IDLE;
            byte_cnt_reg       <= 2'd0;
            n_words_reg        <= '0;
            word_count_reg     <= '0;
            mem_wren_reg       <= 1'b0;
            mem_address_reg    <= '0;
            mem_write_data_reg <= 32'd0;
            in_ready_reg       <= 1'b0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            error_reg          <= 1'b0;
            cpu_reset_n_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            // Status outputs are decoded from the next state so they line up with state_reg.
            in_ready_reg    <= (state_next == ST_HEADER) | (state_next == ST_LOAD) | next_in_check;
            busy_reg        <= (state_next == ST_HEADER) | (state_next == ST_LOAD) |
                               (state_next == ST_LAST) | next_in_check;
            done_reg        <= (state_next == ST_DONE);
            cpu_reset_n_reg <= (state_next == ST_DONE);
            error_reg       <= (state_next == ST_ERROR);
            mem_wren_reg    <= wr_fire;

            if (wr_fire) begin
                mem_address_reg    <= word_count_reg[ADDR_WIDTH-1:0];
                mem_write_data_reg <= word_full;
            end
            if ((state_reg == ST_HEADER) && word_last_byte) begin
                n_words_reg <= word_full[CW-1:0];
            end

            if (start_ok) begin
                byte_cnt_reg    <= 2'd0;
                word_count_reg  <= '0;
                mem_address_reg <= '0;
            end else begin
                if (byte_accept) byte_cnt_reg <= byte_cnt_reg + 2'd1;
                if (mem_wren_reg) word_count_reg <= word_count_reg + CW'(1);
            end
        end
    end

    assign in_ready       = in_ready_reg;
    assign mem_wren       = mem_wren_reg;
    assign mem_address    = mem_address_reg;
    assign mem_write_data = mem_write_data_reg;
    assign cpu_reset_n    = cpu_reset_n_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign error          = error_reg;
    assign word_count     = word_count_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; builds with or without INSTR_MEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_instr_mem_loader;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_wren;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic          cpu_reset_n;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    int            chk_cnt = 0;
    int            pass_cnt = 0;
    logic [7:0]    tb_sum = 8'd0;
    logic [AW-1:0] wr_addr_q [$];
    logic [31:0]   wr_data_q [$];
    logic          prev_wren = 1'b0;
    logic          consec_seen = 1'b0;

    instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_wren(mem_wren),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_wren) begin
            wr_addr_q.push_back(mem_address);
            wr_data_q.push_back(mem_write_data);
        end
        if (mem_wren && prev_wren) consec_seen = 1'b1;
        prev_wren = mem_wren;
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            chk_cnt++;
            $display("FAIL send_timeout: in_ready=%b required 1 for byte %h", in_ready, b);
            in_valid = 1'b0;
        end else begin
            tb_sum = tb_sum + b;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Ends an image: sends the checksum byte when enabled, else waits for the commit edge.
    task automatic finish_image();
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        logic [7:0] ck;
        ck = 8'd0 - tb_sum;
        send_byte(ck);
`else
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        if ({in_ready, mem_wren, cpu_reset_n} !== 3'b000) $display("FAIL reset_ctl: got %b want 000", {in_ready, mem_wren, cpu_reset_n}); else pass_cnt++;
        chk_cnt++;
        if ({busy, done, error} !== 3'b000) $display("FAIL reset_status: got %b want 000", {busy, done, error}); else pass_cnt++;
        chk_cnt++;
        if (word_count !== '0) $display("FAIL reset_word_count: got %0d want 0", word_count); else pass_cnt++;
        chk_cnt++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        if ({in_ready, busy, done} !== 3'b000) $display("FAIL idle_after_reset: got %b want 000", {in_ready, busy, done}); else pass_cnt++;
        chk_cnt++;
    endtask

    task automatic test_basic();
        clear_writes();
        tb_sum = 8'd0;
        pulse_start();
        if ({busy, in_ready} !== 2'b11) $display("FAIL basic_header_state: got %b want 11", {busy, in_ready}); else pass_cnt++;
        chk_cnt++;
        send_word(32'h0000_0002);
        send_word(32'h0000_0013);
        if ({mem_wren, mem_address} !== {1'b1, 10'd0} || mem_write_data !== 32'h13) $display("FAIL basic_write0: got wren=%b addr=%h data=%h want 1/000/00000013", mem_wren, mem_address, mem_write_data); else pass_cnt++;
        chk_cnt++;
        send_word(32'h0000_006F);
        if ({mem_wren, mem_address} !== {1'b1, 10'd1} || mem_write_data !== 32'h6F) $display("FAIL basic_write1: got wren=%b addr=%h data=%h want 1/001/0000006f", mem_wren, mem_address, mem_write_data); else pass_cnt++;
        chk_cnt++;
`ifndef INSTR_MEM_LOADER_CHECKSUM_EN
        if ({in_ready, done, cpu_reset_n} !== 3'b000) $display("FAIL basic_write_cycle_ctl: got %b want 000", {in_ready, done, cpu_reset_n}); else pass_cnt++;
        chk_cnt++;
`endif
        finish_image();
        if ({done, cpu_reset_n, busy, mem_wren} !== 4'b1100) $display("FAIL basic_done: got %b want 1100", {done, cpu_reset_n, busy, mem_wren}); else pass_cnt++;
        chk_cnt++;
        if (word_count !== 11'd2) $display("FAIL basic_word_count: got %0d want 2", word_count); else pass_cnt++;
        chk_cnt++;
        if (wr_addr_q.size() !== 2) $display("FAIL basic_write_count: got %0d want 2", wr_addr_q.size()); else pass_cnt++;
        chk_cnt++;
    endtask

    task automatic test_empty();
        clear_writes();
        tb_sum = 8'd0;
        pulse_start();
        if ({cpu_reset_n, done, busy} !== 3'b001) $display("FAIL empty_restart: got %b want 001", {cpu_reset_n, done, busy}); else pass_cnt++;
        chk_cnt++;
        send_word(32'h0000_0000);
        finish_image();
        if ({done, cpu_reset_n, error} !== 3'b110) $display("FAIL empty_done: got %b want 110", {done, cpu_reset_n, error}); else pass_cnt++;
        chk_cnt++;
        if (wr_addr_q.size() !== 0 || word_count !== '0) $display("FAIL empty_no_writes: got writes=%0d count=%0d want 0/0", wr_addr_q.size(), word_count); else pass_cnt++;
        chk_cnt++;
    endtask

    task automatic test_oversize();
        clear_writes();
        tb_sum = 8'd0;
        pulse_start();
        send_word(32'h0000_0401);
        if ({error, in_ready, cpu_reset_n, done, busy} !== 5'b10000) $display("FAIL oversize_error: got %b want 10000", {error, in_ready, cpu_reset_n, done, busy}); else pass_cnt++;
        chk_cnt++;
        repeat (3) @(negedge clk);
        if (wr_addr_q.size() !== 0 || error !== 1'b1) $display("FAIL oversize_hold: got writes=%0d error=%b want 0/1", wr_addr_q.size(), error); else pass_cnt++;
        chk_cnt++;
        tb_sum = 8'd0;
        pulse_start();
        if ({error, busy} !== 2'b01) $display("FAIL oversize_recover_start: got %b want 01", {error, busy}); else pass_cnt++;
        chk_cnt++;
        send_word(32'h0000_0001);
        send_word(32'hAABB_CCDD);
        finish_image();
        if (done !== 1'b1 || wr_data_q.size() !== 1) $display("FAIL oversize_recover_done: got done=%b writes=%0d want 1/1", done, wr_data_q.size()); else pass_cnt++;
        chk_cnt++;
        if (wr_data_q.size() == 1 && wr_data_q[0] !== 32'hAABB_CCDD) $display("FAIL oversize_recover_data: got %h want aabbccdd", wr_data_q[0]); else pass_cnt++;
        chk_cnt++;
    endtask

    task automatic test_backpressure();
        logic [7:0] bp [8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        clear_writes();
        tb_sum = 8'd0;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send_byte(bp[i]);
            repeat (5) @(negedge clk);
            if (i == 5) begin
                pulse_start();
                if ({busy, in_ready, done} !== 3'b110 || word_count !== '0) $display("FAIL bp_start_ignored: got %b count=%0d want 110/0", {busy, in_ready, done}, word_count); else pass_cnt++;
                chk_cnt++;
            end
        end
        finish_image();
        if (done !== 1'b1 || word_count !== 11'd1) $display("FAIL bp_done: got done=%b count=%0d want 1/1", done, word_count); else pass_cnt++;
        chk_cnt++;
        if (wr_addr_q.size() !== 1) $display("FAIL bp_write_count: got %0d want 1", wr_addr_q.size()); else pass_cnt++;
        chk_cnt++;
        if (wr_addr_q.size() == 1 && (wr_addr_q[0] !== 10'd0 || wr_data_q[0] !== 32'h1234_5678)) $display("FAIL bp_write: got addr=%h data=%h want 000/12345678", wr_addr_q[0], wr_data_q[0]); else pass_cnt++;
        chk_cnt++;
    endtask

    task automatic test_max_image();
        int bad = 0;
        clear_writes();
        tb_sum = 8'd0;
        pulse_start();
        send_word(32'h0000_0400);
        for (int i = 0; i < 1024; i++) send_word(32'hA500_0000 | i);
        finish_image();
        if (done !== 1'b1 || word_count !== 11'h400) $display("FAIL max_done: got done=%b count=%0d want 1/1024", done, word_count); else pass_cnt++;
        chk_cnt++;
        if (wr_addr_q.size() !== 1024) $display("FAIL max_write_count: got %0d want 1024", wr_addr_q.size()); else pass_cnt++;
        chk_cnt++;
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] !== 10'(i) || wr_data_q[i] !== (32'hA500_0000 | i)) bad++;
        end
        if (bad !== 0) $display("FAIL max_write_contents: got %0d bad writes want 0", bad); else pass_cnt++;
        chk_cnt++;
    endtask

    task automatic test_reset_midload();
        clear_writes();
        tb_sum = 8'd0;
        pulse_start();
        send_word(32'h0000_0002);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        if ({in_ready, mem_wren, cpu_reset_n, busy, done, error} !== 6'b000000 || word_count !== '0) $display("FAIL midload_reset: got %b count=%0d want 000000/0", {in_ready, mem_wren, cpu_reset_n, busy, done, error}, word_count); else pass_cnt++;
        chk_cnt++;
        if (mem_address !== '0 || mem_write_data !== 32'd0) $display("FAIL midload_reset_bus: got addr=%h data=%h want 0/0", mem_address, mem_write_data); else pass_cnt++;
        chk_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        clear_writes();
        tb_sum = 8'd0;
        pulse_start();
        send_word(32'h0000_0001);
        send_word(32'h1122_3344);
        finish_image();
        if (done !== 1'b1 || wr_addr_q.size() !== 1) $display("FAIL midload_restart: got done=%b writes=%0d want 1/1", done, wr_addr_q.size()); else pass_cnt++;
        chk_cnt++;
        if (wr_addr_q.size() == 1 && (wr_addr_q[0] !== 10'd0 || wr_data_q[0] !== 32'h1122_3344)) $display("FAIL midload_restart_write: got addr=%h data=%h want 000/11223344", wr_addr_q[0], wr_data_q[0]); else pass_cnt++;
        chk_cnt++;
        if (consec_seen !== 1'b0) $display("FAIL wren_consecutive: got %b want 0", consec_seen); else pass_cnt++;
        chk_cnt++;
    endtask

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send_word(32'h0000_0001);
        send_word(32'h0403_0201);
        if ({busy, in_ready, done} !== 3'b110) $display("FAIL ck_check_state: got %b want 110", {busy, in_ready, done}); else pass_cnt++;
        chk_cnt++;
        send_byte(8'hF5);
        if ({done, error, cpu_reset_n} !== 3'b101) $display("FAIL ck_good: got %b want 101", {done, error, cpu_reset_n}); else pass_cnt++;
        chk_cnt++;
        pulse_start();
        send_word(32'h0000_0001);
        send_word(32'h0403_0201);
        send_byte(8'hF4);
        if ({done, error, cpu_reset_n} !== 3'b010 || word_count !== 11'd1) $display("FAIL ck_bad: got %b count=%0d want 010/1", {done, error, cpu_reset_n}, word_count); else pass_cnt++;
        chk_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_oversize();
        test_backpressure();
        test_max_image();
        test_reset_midload();
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
